// File: rtl/logic_gate_pkg.sv
// Shared types and constants for the logic gate truth-table tester.
// Gate indices follow the bit order of the gate block's 7-bit output bus.
package logic_gate_pkg;

    localparam int NUM_GATES   = 7;
    localparam int NUM_VECTORS = 4;

    localparam int GATE_AND  = 0;
    localparam int GATE_OR   = 1;
    localparam int GATE_NOTA = 2;
    localparam int GATE_NAND = 3;
    localparam int GATE_NOR  = 4;
    localparam int GATE_XOR  = 5;
    localparam int GATE_XNOR = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

endpackage

// File: rtl/logic_gate_tester_if.sv
// Control, result and gate-block signals of the tester.
// master: tester side (drives a/b and results); slave: lab top / bench side.
interface logic_gate_tester_if;
    import logic_gate_pkg::*;

    logic                 start;
    logic                 abort;
    logic                 a_drv;
    logic                 b_drv;
    logic [NUM_GATES-1:0] gate_out;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [NUM_GATES-1:0] fail_mask;
    logic [2:0]           err_count;
    logic [1:0]           first_fail_vec;
    logic                 first_fail_valid;

    modport master (
        input  start, abort, gate_out,
        output a_drv, b_drv, busy, done, pass,
        output fail_mask, err_count,
        output first_fail_vec, first_fail_valid
    );

    modport slave (
        output start, abort, gate_out,
        input  a_drv, b_drv, busy, done, pass,
        input  fail_mask, err_count,
        input  first_fail_vec, first_fail_valid
    );

endinterface

// File: rtl/gate_golden_model.sv
// Combinational golden model of the two-input gate block.
// Ports: i_vec = {a,b}; o_expected = gate outputs in gate_out bit order.
module gate_golden_model
    import logic_gate_pkg::*;
(
    input  logic [1:0]           i_vec,
    output logic [NUM_GATES-1:0] o_expected
);

    logic w_a;
    logic w_b;

    assign w_a = i_vec[1];
    assign w_b = i_vec[0];

    always_comb begin
        o_expected            = '0;
        o_expected[GATE_AND]  = w_a & w_b;
        o_expected[GATE_OR]   = w_a | w_b;
        o_expected[GATE_NOTA] = ~w_a;
        o_expected[GATE_NAND] = ~(w_a & w_b);
        o_expected[GATE_NOR]  = ~(w_a | w_b);
        o_expected[GATE_XOR]  = w_a ^ w_b;
        o_expected[GATE_XNOR] = ~(w_a ^ w_b);
    end

endmodule

// File: rtl/logic_gate_tester.sv
// Truth-table sequencer: steps {a,b} through 00..11, settles, compares.
// Ports: clk, rst (async high); bus = tester side of logic_gate_tester_if.
module logic_gate_tester
    import logic_gate_pkg::*;
#(
    parameter int                   SETTLE_CYCLES = 2,
    parameter logic [NUM_GATES-1:0] CHECK_MASK    = 7'h7F
) (
    input  logic                clk,
    input  logic                rst,
    logic_gate_tester_if.master bus
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t               r_state;
    logic [1:0]           r_vec;
    logic [3:0]           r_settle;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;
    logic [NUM_GATES-1:0] r_fail_mask;
    logic [2:0]           r_err_count;
    logic [1:0]           r_ff_vec;
    logic                 r_ff_valid;

    logic [NUM_GATES-1:0] w_expected;
    logic [NUM_GATES-1:0] w_mism;
    logic                 w_abort;

    gate_golden_model u_golden (
        .i_vec      (r_vec),
        .o_expected (w_expected)
    );

    assign w_mism  = (bus.gate_out ^ w_expected) & CHECK_MASK;
    assign w_abort = bus.abort &&
                     (r_state inside {S_APPLY, S_SETTLE, S_CHECK});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_vec       <= '0;
            r_settle    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_mask <= '0;
            r_err_count <= '0;
            r_ff_vec    <= '0;
            r_ff_valid  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Abort wins over the CHECK update; partial results are kept.
            if (w_abort) begin
                r_state <= S_IDLE;
                r_vec   <= '0;
                r_pass  <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_fail_mask <= '0;
                            r_err_count <= '0;
                            r_ff_valid  <= 1'b0;
                            r_pass      <= 1'b0;
                            r_vec       <= '0;
                            r_busy      <= 1'b1;
                            r_state     <= S_APPLY;
                        end
                    end
                    S_APPLY: begin
                        r_settle <= SETTLE_LOAD;
                        r_state  <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (r_settle == 4'd0) begin
                            r_state <= S_CHECK;
                        end else begin
                            r_settle <= r_settle - 4'd1;
                        end
                    end
                    S_CHECK: begin
                        r_fail_mask <= r_fail_mask | w_mism;
                        if (w_mism != '0) begin
                            r_err_count <= r_err_count + 3'd1;
                            if (!r_ff_valid) begin
                                r_ff_vec   <= r_vec;
                                r_ff_valid <= 1'b1;
                            end
                        end
                        if (r_vec == 2'd3) begin
                            // Pass is decided on the mask including this check.
                            r_pass  <= ((r_fail_mask | w_mism) == '0);
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_vec   <= r_vec + 2'd1;
                            r_state <= S_APPLY;
                        end
                    end
                    S_DONE: begin
                        r_vec   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.a_drv            = r_vec[1];
    assign bus.b_drv            = r_vec[0];
    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
    assign bus.pass             = r_pass;
    assign bus.fail_mask        = r_fail_mask;
    assign bus.err_count        = r_err_count;
    assign bus.first_fail_vec   = r_ff_vec;
    assign bus.first_fail_valid = r_ff_valid;

endmodule
